// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO.
// Captures one record per cycle in which the core writes a GPR and/or a CSR,
// and queues it for a lockstep checker or debug port on a valid/ready
// interface. The core is never stalled: when the queue is full and nothing
// drains, the record is dropped. A drop sets a sticky overflow flag and
// increments a saturating drop counter. Every event takes a sequence number,
// including dropped events, so a drop shows up as a gap in trace_seq_o.
module commit_trace_fifo #(
  parameter int XLEN    = 32,
  parameter int NB_REGS = 5,
  parameter int DEPTH   = 8,
  parameter int SEQ_W   = 16,
  parameter int DROP_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     write_valid_i,
  input  logic [NB_REGS-1:0]       write_adr_i,
  input  logic [XLEN-1:0]          write_data_i,
  input  logic                     write_csr_v_i,
  input  logic [11:0]              csr_adr_i,
  input  logic [XLEN-1:0]          csr_data_i,
  input  logic [XLEN-1:0]          pc_val_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic                     trace_rd_v_o,
  output logic [NB_REGS-1:0]       trace_rd_adr_o,
  output logic [XLEN-1:0]          trace_rd_data_o,
  output logic                     trace_csr_v_o,
  output logic [11:0]              trace_csr_adr_o,
  output logic [XLEN-1:0]          trace_csr_data_o,
  output logic [SEQ_W-1:0]         trace_seq_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Record storage. It is not reset, because the output mask hides it while it is empty.
  logic [XLEN-1:0]    pc_mem_r       [DEPTH];
  logic               rd_v_mem_r     [DEPTH];
  logic [NB_REGS-1:0] rd_adr_mem_r   [DEPTH];
  logic [XLEN-1:0]    rd_data_mem_r  [DEPTH];
  logic               csr_v_mem_r    [DEPTH];
  logic [11:0]        csr_adr_mem_r  [DEPTH];
  logic [XLEN-1:0]    csr_data_mem_r [DEPTH];
  logic [SEQ_W-1:0]   seq_mem_r      [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_nxt_s;
  logic              valid_r;
  logic [SEQ_W-1:0]  seq_r;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic evt_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // A full queue accepts a new record when the head leaves on the same edge.
  assign evt_s  = write_valid_i | write_csr_v_i;
  assign full_s = (level_r == LVL_W'(DEPTH));
  assign pop_s  = valid_r & trace_ready_i;
  assign push_s = evt_s & (~full_s | pop_s);
  assign drop_s = evt_s & full_s & ~pop_s;

  // Compute the next occupancy. Clear takes priority over push and pop.
  always_comb begin
    level_nxt_s = level_r;
    if (clear_i) begin
      level_nxt_s = {LVL_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level_r + LVL_W'(1);
        2'b01:   level_nxt_s = level_r - LVL_W'(1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Update the pointers, occupancy, sequence number and drop bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      valid_r    <= 1'b0;
      seq_r      <= {SEQ_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      valid_r    <= 1'b0;
      seq_r      <= {SEQ_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != {LVL_W{1'b0}});
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (evt_s) begin
        seq_r <= seq_r + SEQ_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {DROP_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + DROP_W'(1);
        end
      end
    end
  end

  // Write the captured record at the write pointer. A field whose valid flag is clear is stored as zero.
  always_ff @(posedge clk) begin
    if (push_s && !clear_i) begin
      pc_mem_r[wr_ptr_r]       <= pc_val_i;
      rd_v_mem_r[wr_ptr_r]     <= write_valid_i;
      rd_adr_mem_r[wr_ptr_r]   <= write_valid_i ? write_adr_i  : {NB_REGS{1'b0}};
      rd_data_mem_r[wr_ptr_r]  <= write_valid_i ? write_data_i : {XLEN{1'b0}};
      csr_v_mem_r[wr_ptr_r]    <= write_csr_v_i;
      csr_adr_mem_r[wr_ptr_r]  <= write_csr_v_i ? csr_adr_i    : 12'h000;
      csr_data_mem_r[wr_ptr_r] <= write_csr_v_i ? csr_data_i   : {XLEN{1'b0}};
      seq_mem_r[wr_ptr_r]      <= seq_r;
    end
  end

  // Present the head record, forced to zero while the queue is empty.
  always_comb begin
    if (valid_r) begin
      trace_pc_o       = pc_mem_r[rd_ptr_r];
      trace_rd_v_o     = rd_v_mem_r[rd_ptr_r];
      trace_rd_adr_o   = rd_adr_mem_r[rd_ptr_r];
      trace_rd_data_o  = rd_data_mem_r[rd_ptr_r];
      trace_csr_v_o    = csr_v_mem_r[rd_ptr_r];
      trace_csr_adr_o  = csr_adr_mem_r[rd_ptr_r];
      trace_csr_data_o = csr_data_mem_r[rd_ptr_r];
      trace_seq_o      = seq_mem_r[rd_ptr_r];
    end else begin
      trace_pc_o       = {XLEN{1'b0}};
      trace_rd_v_o     = 1'b0;
      trace_rd_adr_o   = {NB_REGS{1'b0}};
      trace_rd_data_o  = {XLEN{1'b0}};
      trace_csr_v_o    = 1'b0;
      trace_csr_adr_o  = 12'h000;
      trace_csr_data_o = {XLEN{1'b0}};
      trace_seq_o      = {SEQ_W{1'b0}};
    end
  end

  assign trace_valid_o = valid_r;
  assign level_o       = level_r;
  assign overflow_o    = overflow_r;
  assign drop_cnt_o    = drop_cnt_r;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo with a four-entry queue.
module tb_commit_trace_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_i;
  logic        write_valid_i;
  logic [4:0]  write_adr_i;
  logic [31:0] write_data_i;
  logic        write_csr_v_i;
  logic [11:0] csr_adr_i;
  logic [31:0] csr_data_i;
  logic [31:0] pc_val_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic        trace_rd_v_o;
  logic [4:0]  trace_rd_adr_o;
  logic [31:0] trace_rd_data_o;
  logic        trace_csr_v_o;
  logic [11:0] trace_csr_adr_o;
  logic [31:0] trace_csr_data_o;
  logic [15:0] trace_seq_o;
  logic [2:0]  level_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;

  commit_trace_fifo #(.XLEN(32), .NB_REGS(5), .DEPTH(4), .SEQ_W(16), .DROP_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i),
    .write_valid_i(write_valid_i), .write_adr_i(write_adr_i), .write_data_i(write_data_i),
    .write_csr_v_i(write_csr_v_i), .csr_adr_i(csr_adr_i), .csr_data_i(csr_data_i),
    .pc_val_i(pc_val_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_rd_v_o(trace_rd_v_o), .trace_rd_adr_o(trace_rd_adr_o),
    .trace_rd_data_o(trace_rd_data_o), .trace_csr_v_o(trace_csr_v_o),
    .trace_csr_adr_o(trace_csr_adr_o), .trace_csr_data_o(trace_csr_data_o),
    .trace_seq_o(trace_seq_o), .level_o(level_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic gv, input logic [4:0] ga, input logic [31:0] gd,
                       input logic cv, input logic [11:0] ca, input logic [31:0] cd,
                       input logic [31:0] pc);
    write_valid_i = gv; write_adr_i = ga; write_data_i = gd;
    write_csr_v_i = cv; csr_adr_i = ca; csr_data_i = cd; pc_val_i = pc;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 12'h000, 32'h0, 32'h0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear_i = 1'b0; trace_ready_i = 1'b0;
    idle();
    repeat (3) tick();
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", trace_valid_o); end
    checks++; if (overflow_o !== 1'b0 || drop_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_drop: got ovf=%b cnt=%h expected 0/0000", overflow_o, drop_cnt_o); end
    checks++; if (trace_pc_o !== 32'h0 || trace_seq_o !== 16'h0) begin errors++; $display("FAIL reset_mask: got pc=%h seq=%h expected 0", trace_pc_o, trace_seq_o); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_gpr();
    trace_ready_i = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 12'h123, 32'h12345678, 32'h80000000);
    tick();
    idle();
    checks++; if (trace_valid_o !== 1'b1 || level_o !== 3'd1) begin errors++; $display("FAIL gpr_valid: got v=%b lvl=%0d expected 1/1", trace_valid_o, level_o); end
    checks++; if (trace_pc_o !== 32'h80000000) begin errors++; $display("FAIL gpr_pc: got %h expected 80000000", trace_pc_o); end
    checks++; if (trace_rd_v_o !== 1'b1 || trace_rd_adr_o !== 5'd5 || trace_rd_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL gpr_rd: got v=%b adr=%0d data=%h expected 1/5/deadbeef", trace_rd_v_o, trace_rd_adr_o, trace_rd_data_o); end
    checks++; if (trace_csr_v_o !== 1'b0 || trace_csr_adr_o !== 12'h0 || trace_csr_data_o !== 32'h0) begin errors++; $display("FAIL gpr_csr_zero: got v=%b adr=%h data=%h expected 0/000/0", trace_csr_v_o, trace_csr_adr_o, trace_csr_data_o); end
    checks++; if (trace_seq_o !== 16'd0) begin errors++; $display("FAIL gpr_seq: got %0d expected 0", trace_seq_o); end
    tick();
    checks++; if (trace_valid_o !== 1'b0 || level_o !== 3'd0 || trace_rd_data_o !== 32'h0) begin errors++; $display("FAIL gpr_drain: got v=%b lvl=%0d data=%h expected 0/0/0", trace_valid_o, level_o, trace_rd_data_o); end
  endtask

  task automatic test_dual_write();
    trace_ready_i = 1'b0;
    drive(1'b1, 5'd1, 32'h10, 1'b1, 12'h341, 32'h80000004, 32'h80000010);
    tick();
    idle();
    checks++; if (level_o !== 3'd1 || trace_rd_v_o !== 1'b1 || trace_csr_v_o !== 1'b1) begin errors++; $display("FAIL dual_flags: got lvl=%0d rdv=%b csrv=%b expected 1/1/1", level_o, trace_rd_v_o, trace_csr_v_o); end
    checks++; if (trace_rd_adr_o !== 5'd1 || trace_rd_data_o !== 32'h10) begin errors++; $display("FAIL dual_rd: got adr=%0d data=%h expected 1/10", trace_rd_adr_o, trace_rd_data_o); end
    checks++; if (trace_csr_adr_o !== 12'h341 || trace_csr_data_o !== 32'h80000004) begin errors++; $display("FAIL dual_csr: got adr=%h data=%h expected 341/80000004", trace_csr_adr_o, trace_csr_data_o); end
    checks++; if (trace_seq_o !== 16'd1) begin errors++; $display("FAIL dual_seq: got %0d expected 1", trace_seq_o); end
    tick();
    checks++; if (trace_seq_o !== 16'd1 || level_o !== 3'd1) begin errors++; $display("FAIL dual_hold: got seq=%0d lvl=%0d expected 1/1", trace_seq_o, level_o); end
    trace_ready_i = 1'b1;
    tick();
    trace_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL ovf_clear: got %0d expected 0", level_o); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 1'b0, 12'h000, 32'h0, 32'h100 + 32'(4 * i));
      tick();
    end
    idle();
    checks++; if (level_o !== 3'd4 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_state: got lvl=%0d ovf=%b cnt=%0d expected 4/1/2", level_o, overflow_o, drop_cnt_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_seq_o !== 16'(i) || trace_rd_data_o !== 32'(i) || trace_pc_o !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL ovf_drain%0d: got seq=%0d data=%h pc=%h expected %0d", i, trace_seq_o, trace_rd_data_o, trace_pc_o, i); end
      tick();
    end
    checks++; if (level_o !== 3'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty: got lvl=%0d v=%b expected 0/0", level_o, trace_valid_o); end
    drive(1'b1, 5'd7, 32'h77, 1'b0, 12'h000, 32'h0, 32'h200);
    tick();
    idle();
    checks++; if (trace_seq_o !== 16'd6 || trace_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_gap_seq: got seq=%0d v=%b expected 6/1", trace_seq_o, trace_valid_o); end
    tick();
    trace_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd3, 32'(i), 1'b0, 12'h000, 32'h0, 32'h300);
      tick();
    end
    checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL fpp_full: got %0d expected 4", level_o); end
    trace_ready_i = 1'b1;
    drive(1'b1, 5'd3, 32'hAA, 1'b0, 12'h000, 32'h0, 32'h300);
    tick();
    idle();
    checks++; if (level_o !== 3'd4 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL fpp_nodrop: got lvl=%0d cnt=%0d ovf=%b expected 4/0/0", level_o, drop_cnt_o, overflow_o); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (trace_seq_o !== 16'(i) || trace_rd_data_o !== ((i == 4) ? 32'hAA : 32'(i))) begin errors++; $display("FAIL fpp_drain%0d: got seq=%0d data=%h expected seq %0d", i, trace_seq_o, trace_rd_data_o, i); end
      tick();
    end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL fpp_empty: got %0d expected 0", level_o); end
    trace_ready_i = 1'b0;
  endtask

  task automatic test_saturate_wrap();
    do_clear();
    drive(1'b1, 5'd9, 32'h9, 1'b0, 12'h000, 32'h0, 32'h400);
    repeat (65536) tick();
    idle();
    checks++; if (level_o !== 3'd4 || drop_cnt_o !== 16'hFFFC || overflow_o !== 1'b1) begin errors++; $display("FAIL sat_bulk: got lvl=%0d cnt=%h ovf=%b expected 4/fffc/1", level_o, drop_cnt_o, overflow_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_seq_o !== 16'(i)) begin errors++; $display("FAIL sat_drain%0d: got %0d expected %0d", i, trace_seq_o, i); end
      tick();
    end
    trace_ready_i = 1'b0;
    drive(1'b1, 5'd9, 32'h9, 1'b0, 12'h000, 32'h0, 32'h400);
    tick();
    checks++; if (trace_seq_o !== 16'd0 || level_o !== 3'd1) begin errors++; $display("FAIL sat_wrap_seq: got seq=%0d lvl=%0d expected 0/1", trace_seq_o, level_o); end
    repeat (3) tick();
    checks++; if (level_o !== 3'd4 || drop_cnt_o !== 16'hFFFC) begin errors++; $display("FAIL sat_refill: got lvl=%0d cnt=%h expected 4/fffc", level_o, drop_cnt_o); end
    repeat (3) tick();
    checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", drop_cnt_o); end
    repeat (2) tick();
    idle();
    checks++; if (drop_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", drop_cnt_o); end
  endtask

  task automatic test_clear_reset();
    trace_ready_i = 1'b1;
    tick();
    trace_ready_i = 1'b0;
    checks++; if (level_o !== 3'd3 || overflow_o !== 1'b1) begin errors++; $display("FAIL cr_pre: got lvl=%0d ovf=%b expected 3/1", level_o, overflow_o); end
    clear_i = 1'b1;
    drive(1'b1, 5'd2, 32'h22, 1'b0, 12'h000, 32'h0, 32'h500);
    tick();
    clear_i = 1'b0;
    idle();
    checks++; if (level_o !== 3'd0 || trace_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL cr_clear: got lvl=%0d v=%b ovf=%b cnt=%0d expected 0/0/0/0", level_o, trace_valid_o, overflow_o, drop_cnt_o); end
    drive(1'b1, 5'd2, 32'h22, 1'b0, 12'h000, 32'h0, 32'h504);
    tick();
    checks++; if (trace_seq_o !== 16'd0 || level_o !== 3'd1) begin errors++; $display("FAIL cr_clear_seq: got seq=%0d lvl=%0d expected 0/1", trace_seq_o, level_o); end
    repeat (4) tick();
    idle();
    checks++; if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin errors++; $display("FAIL cr_refill: got ovf=%b cnt=%0d expected 1/1", overflow_o, drop_cnt_o); end
    trace_ready_i = 1'b1;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (level_o !== 3'd0 || trace_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin errors++; $display("FAIL cr_async_reset: got lvl=%0d v=%b ovf=%b cnt=%0d expected 0/0/0/0", level_o, trace_valid_o, overflow_o, drop_cnt_o); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    trace_ready_i = 1'b0;
    drive(1'b1, 5'd4, 32'h44, 1'b0, 12'h000, 32'h0, 32'h600);
    tick();
    idle();
    checks++; if (trace_seq_o !== 16'd0 || level_o !== 3'd1 || trace_rd_data_o !== 32'h44) begin errors++; $display("FAIL cr_post_reset: got seq=%0d lvl=%0d data=%h expected 0/1/44", trace_seq_o, level_o, trace_rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_single_gpr();
    test_dual_write();
    test_overflow();
    test_full_push_pop();
    test_saturate_wrap();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
